// File: rtl/switch_hex_counter.sv
// Per-channel switch synchroniser + debouncer driving LEDs and a hex rise counter per digit.
// Optional macro SWITCH_HEX_COUNTER_DP_EN lights each digit's decimal point while its switch is on.
module switch_hex_counter #(
    parameter int CHANNELS        = 6,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic [CHANNELS-1:0]   SW,
    output logic [CHANNELS-1:0]   LEDR,
    output logic [8*CHANNELS-1:0] HEX
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] deb;
    logic [CW-1:0]       cnt   [CHANNELS];
    logic [3:0]          rises [CHANNELS];

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt[i]   <= '0;
                rises[i] <= '0;
            end
        end else begin
            sync1 <= SW;
            sync2 <= sync1;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    // Level held long enough: accept it and count rising edges only.
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                    if (sync2[i])
                        rises[i] <= rises[i] + 4'd1;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign LEDR = deb;

    always_comb begin
        HEX = '1;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
`ifdef SWITCH_HEX_COUNTER_DP_EN
            HEX[8*i+7] = ~deb[i];
`else
            HEX[8*i+7] = 1'b1;
`endif
            HEX[8*i +: 7] = seg7(rises[i]);
        end
    end

endmodule

// File: tb/tb_switch_hex_counter.sv
// Directed self-checking bench for switch_hex_counter with CHANNELS=6, DEBOUNCE_CYCLES=4.
module tb_switch_hex_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  sw;
    logic [5:0]  ledr;
    logic [47:0] hex;

    int checks = 0;
    int passes = 0;

    switch_hex_counter #(
        .CHANNELS(6),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .SW      (sw),
        .LEDR    (ledr),
        .HEX     (hex)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Expected digit byte: DP lit only when the macro is on and the switch is accepted high.
    function automatic logic [7:0] dig(input logic [6:0] seg, input logic lit);
`ifdef SWITCH_HEX_COUNTER_DP_EN
        return {~lit, seg};
`else
        return {1'b1, seg};
`endif
    endfunction

    initial begin
        // Reset held with all switches high
        rst_n = 1'b0;
        sw    = 6'b111111;
        tick(3);
        chk("rst_ledr", 48'(ledr), 48'h0);
        chk("rst_hex",  hex, 48'hC0C0C0C0C0C0);
        rst_n = 1'b1;
        tick(5);
        chk("rel_ledr_before", 48'(ledr), 48'h0);
        tick(1);
        chk("rel_ledr_at6", 48'(ledr), 48'h3F);
        chk("rel_hex_at6", hex, {6{dig(7'h79, 1'b1)}});

        // Falling edges must not touch the rise counters
        sw = 6'b000000;
        tick(6);
        chk("fall_ledr", 48'(ledr), 48'h0);
        chk("fall_hex",  hex, {6{dig(7'h79, 1'b0)}});

        // Fresh reset, then a 3-cycle glitch on channel 0
        rst_n = 1'b0;
        tick(2);
        chk("rst2_hex", hex, 48'hC0C0C0C0C0C0);
        rst_n = 1'b1;
        tick(2);
        sw[0] = 1'b1;
        tick(3);
        sw[0] = 1'b0;
        tick(10);
        chk("glitch_ledr", 48'(ledr), 48'h0);
        chk("glitch_hex0", 48'(hex[7:0]), 48'hC0);

        // Seventeen clean pulses on channel 2: count wraps through 0 to 1
        for (int r = 1; r <= 17; r++) begin
            sw[2] = 1'b1;
            tick(10);
            if (r == 1) chk("ch2_high_ledr", 48'(ledr), 48'h04);
            sw[2] = 1'b0;
            tick(10);
            if (r == 10) chk("ch2_cnt_A", 48'(hex[22:16]), 48'h08);
            if (r == 16) chk("ch2_cnt_wrap0", 48'(hex[22:16]), 48'h40);
        end
        chk("ch2_cnt_wrap1", 48'(hex[22:16]), 48'h79);
        chk("ch2_others", hex, {8'hC0, 8'hC0, 8'hC0, dig(7'h79, 1'b0), 8'hC0, 8'hC0});
        chk("ch2_ledr", 48'(ledr), 48'h0);

        // Pulse of exactly DEBOUNCE_CYCLES is accepted
        sw[0] = 1'b1;
        tick(4);
        sw[0] = 1'b0;
        tick(1);
        chk("exact_before", 48'(ledr), 48'h0);
        tick(1);
        chk("exact_ledr", 48'(ledr), 48'h01);
        chk("exact_hex0", 48'(hex[7:0]), 48'(dig(7'h79, 1'b1)));
        tick(10);
        chk("exact_after", 48'(ledr), 48'h0);
        chk("exact_hex0_after", 48'(hex[7:0]), 48'(dig(7'h79, 1'b0)));

        // All channels rise together from a fresh reset
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        sw = 6'b111111;
        tick(5);
        chk("simul_before", 48'(ledr), 48'h0);
        tick(1);
        chk("simul_ledr", 48'(ledr), 48'h3F);
        chk("simul_hex", hex, {6{dig(7'h79, 1'b1)}});

        // Reset during a pending debounce on channel 3
        sw = 6'b000000;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        sw[3] = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(2);
        chk("midrst_ledr", 48'(ledr), 48'h0);
        chk("midrst_hex", hex, 48'hC0C0C0C0C0C0);
        rst_n = 1'b1;
        tick(5);
        chk("midrst_before", 48'(ledr), 48'h0);
        tick(1);
        chk("midrst_ledr_acc", 48'(ledr), 48'h08);
        chk("midrst_hex3", 48'(hex[31:24]), 48'(dig(7'h79, 1'b1)));

        // Decimal point of channel 1 follows the build option
        sw[1] = 1'b1;
        tick(6);
        chk("dp_ledr", 48'(ledr), 48'h0A);
`ifdef SWITCH_HEX_COUNTER_DP_EN
        chk("dp_ch1", 48'(hex[15]), 48'h0);
`else
        chk("dp_ch1", 48'(hex[15]), 48'h1);
`endif
        chk("dp_ch0", 48'(hex[7]), 48'h1);
        chk("dp_hex", hex, {8'hC0, 8'hC0, dig(7'h79, 1'b1), 8'hC0, dig(7'h79, 1'b1), 8'hC0});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
